jet_spi_master: RTL
===================

// Module: jet_spi_master
// PURPOSE
//  SPI master (initiator) for the jet register protocol; FPGA drives cs/sclk to a remote jet slave.
//  Frame: cs low, header word {rw,addr[14:0]}, then len data words, MSB first, cs high.
//  Write (rw=1): streams tx words out on MOSI. Read (rw=0): MOSI=0, MISO words returned on rx port.
//  Sits beside the host-side sequencer; the slave is the FPGA SPI register target on the far board.
// PARAMETERS
//  CLK_DIV    4   clk_i cycles per sclk half-period (>=2)
//  CS_GAP     22  clk_i cycles cs held high after a frame before busy_o drops
//  LEN_W      15  width of word-count input
// PORTS
//  clk_i       in   1      system clock
//  reset_i     in   1      asynchronous, active-low reset
//  start_i     in   1      1-cycle pulse: latch rw_i/addr_i/len_i, begin frame (ignored while busy_o)
//  rw_i        in   1      1=write, 0=read
//  addr_i      in   15     register address -> header[14:0]
//  len_i       in   LEN_W  data words after header (0 = header only)
//  tx_data_i   in   16     write word
//  tx_valid_i  in   1      tx_data_i valid
//  tx_ready_o  out  1      word accepted when tx_valid_i & tx_ready_o
//  rx_data_o   out  16     read word
//  rx_valid_o  out  1      1-cycle pulse per received word
//  busy_o      out  1      high from cycle after start_i until CS_GAP elapsed
//  done_o      out  1      1-cycle pulse when cs returns high
//  spi_cs      out  1      chip select, active low
//  spi_sclk    out  1      serial clock, idle low (mode 0)
//  spi_mosi    out  1      master out
//  spi_miso    in   1      master in (2-flop synchronised)
// BEHAVIOUR
//  Reset: spi_cs=1, spi_sclk=0, spi_mosi=0, busy_o=0, done_o=0, tx_ready_o=0, rx_valid_o=0, rx_data_o=0.
//  Reset mid-frame: cs rises asynchronously, frame discarded, no done_o.
//  FSM: IDLE -> SETUP -> SHIFT <-> LOAD -> GAP -> IDLE.
//   IDLE : start_i latches header; next cycle spi_cs=0, busy_o=1, MOSI=header[15].
//   SETUP: CLK_DIV cycles cs-to-first-edge; -> SHIFT.
//   SHIFT: sclk low CLK_DIV cycles then high CLK_DIV; MISO sampled on sclk rise (via sync, compensated 2 cycles);
//          MOSI updates on sclk fall. After 16th bit's high phase -> LOAD.
//   LOAD : sclk low. Words remaining==0 -> GAP. Write: tx_ready_o=1 until tx_valid_i; on accept, load
//          shifter, -> SHIFT. No valid word: stall indefinitely with sclk low, cs low (underrun hold).
//          Read: pulse rx_valid_o with completed word (not for header), load zeros, -> SHIFT.
//   GAP  : spi_cs=1 and done_o pulse on entry; CS_GAP cycles; busy_o drops on exit.
//  tx_data_i may be prefetched: tx_ready_o asserts during last word's SHIFT so no stall at CLK_DIV>=2.
//  Read of final word: rx_valid_o pulses in LOAD before GAP, i.e. before done_o.
//  Bit time 2*CLK_DIV clocks; frame cs-low time = CLK_DIV + 16*(len+1)*2*CLK_DIV (+ stalls).
//  Word counter 15 bit, no wrap: len_i=0x7FFF valid. start_i during busy_o: ignored, no effect.
//  tx words presented in read frames are not consumed (tx_ready_o stays 0).
// CONFIGURATION
//  JET_SPI_CHKSUM_EN defined: after last data word an extra word is shifted = 16-bit modulo sum of
//   header and all data words (write: sent on MOSI; read: received word compared to local sum of
//   header+rx words, result on extra output chk_err_o, valid with done_o, reset 0). Not reported on rx port.
//  Not defined: no trailer word, chk_err_o port absent, frame ends after len words.
// TESTING
//  1 Reset: hold reset_i=0 -> spi_cs=1, spi_sclk=0, busy_o=0; release mid-frame -> cs=1 within same cycle.
//  2 Write rw=1 addr=0x0040 len=2, tx 0x1234,0x4321 -> MOSI 0x8040,0x1234,0x4321; 48 sclk rises; done_o once.
//  3 Read rw=0 addr=0x0040 len=3, slave returns 0x0002,0x0004,0x0006 -> rx_valid_o x3 with those
//    values, MOSI words 0x0040,0x0000,0x0000,0x0000.
//  4 Underrun: write len=2, tx_valid_i withheld 100 cycles before word 2 -> sclk low, cs low throughout,
//    resumes with correct bits; total sclk rises still 48.
//  5 len=0 read addr=0x7FFF -> one header word 0x7FFF, no rx_valid_o, busy_o low CS_GAP=22 cycles after cs rise;
//    start_i pulsed mid-frame ignored.
//  6 JET_SPI_CHKSUM_EN: write 0x8040,0x1234 -> trailer 0x9274; read with corrupted trailer -> chk_err_o=1.

Source files
------------

// File: rtl/jet_spi_master.sv
`timescale 1ns/1ps
// jet_spi_master: SPI mode-0 initiator for the jet register protocol.
// A frame is cs low, header {rw, addr[14:0]}, then len 16-bit data words MSB first, then cs
// high for CS_GAP cycles. Writes stream tx words on MOSI; reads return MISO words on rx_*.
// Build option JET_SPI_CHKSUM_EN: appends a trailer word holding the 16-bit modulo sum of the
// header and data words, and adds the chk_err_o output (read trailer mismatch, valid with done_o).
module jet_spi_master #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 22,
  parameter int unsigned LEN_W   = 15
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             rw_i,
  input  logic [14:0]      addr_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [15:0]      tx_data_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  output logic [15:0]      rx_data_o,
  output logic             rx_valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             spi_cs,
  output logic             spi_sclk,
  output logic             spi_mosi,
  input  logic             spi_miso
`ifdef JET_SPI_CHKSUM_EN
  ,
  output logic             chk_err_o
`endif
);

  localparam int unsigned CntMax = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] DivLast = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] GapLast = CntW'(CS_GAP - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StLoad, StGap} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic [LEN_W-1:0] words_left_q, words_left_d;   // data words still to shift after this one
  logic [LEN_W-1:0] fetch_left_q, fetch_left_d;   // tx words still to accept
  logic             rw_q, rw_d;
  logic             hdr_q, hdr_d;                 // current word is the header
  logic [15:0]      tx_sh_q, tx_sh_d;
  logic [15:0]      rx_sh_q, rx_sh_d;
  logic [15:0]      hold_q, hold_d;               // prefetched tx word
  logic             hold_vld_q, hold_vld_d;
  logic             cs_q, cs_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tx_ready_q, tx_ready_d;
  logic             rx_valid_q, rx_valid_d;
  logic [15:0]      rx_data_q, rx_data_d;
  logic             miso_s1_q, miso_s2_q;
  logic             tx_acc;
  logic             rx_word;

`ifdef JET_SPI_CHKSUM_EN
  logic [15:0]      sum_q, sum_d;
  logic             trl_q, trl_d;                 // current word is the checksum trailer
  logic             chk_err_q, chk_err_d;
  assign rx_word = !hdr_q && !trl_q;
`else
  assign rx_word = !hdr_q;
`endif

  assign tx_acc = tx_valid_i & tx_ready_q;

  // Next-state logic for the frame sequencer and all registered outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    words_left_d = words_left_q;
    fetch_left_d = fetch_left_q;
    rw_d         = rw_q;
    hdr_d        = hdr_q;
    tx_sh_d      = tx_sh_q;
    rx_sh_d      = rx_sh_q;
    hold_d       = hold_q;
    hold_vld_d   = hold_vld_q;
    cs_d         = cs_q;
    sclk_d       = sclk_q;
    mosi_d       = mosi_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    rx_valid_d   = 1'b0;
    rx_data_d    = rx_data_q;
`ifdef JET_SPI_CHKSUM_EN
    sum_d        = sum_q;
    trl_d        = trl_q;
    chk_err_d    = chk_err_q;
`endif

    if (tx_acc) begin
      hold_d       = tx_data_i;
      hold_vld_d   = 1'b1;
      fetch_left_d = fetch_left_q - LEN_W'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d      = StSetup;
          cnt_d        = '0;
          bit_d        = '0;
          cs_d         = 1'b0;
          sclk_d       = 1'b0;
          busy_d       = 1'b1;
          rw_d         = rw_i;
          hdr_d        = 1'b1;
          tx_sh_d      = {rw_i, addr_i};
          mosi_d       = rw_i;
          words_left_d = len_i;
          fetch_left_d = rw_i ? len_i : '0;
          hold_vld_d   = 1'b0;
`ifdef JET_SPI_CHKSUM_EN
          sum_d        = {rw_i, addr_i};
          trl_d        = 1'b0;
`endif
        end
      end

      StSetup: begin
        if (cnt_q == DivLast) begin
          state_d = StShift;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StShift: begin
        if (cnt_q == DivLast) begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // End of high phase: MISO seen through the synchroniser still reflects the rise.
            sclk_d  = 1'b0;
            rx_sh_d = {rx_sh_q[14:0], miso_s2_q};
            if (bit_q == 4'd15) begin
              state_d = StLoad;
              bit_d   = '0;
            end else begin
              bit_d   = bit_q + 4'd1;
              tx_sh_d = {tx_sh_q[14:0], 1'b0};
              mosi_d  = tx_sh_q[14];
            end
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StLoad: begin
        hdr_d = 1'b0;
        if (!rw_q && rx_word) begin
          rx_valid_d = 1'b1;
          rx_data_d  = rx_sh_q;
`ifdef JET_SPI_CHKSUM_EN
          sum_d      = sum_q + rx_sh_q;
`endif
        end
        if (words_left_q == '0) begin
`ifdef JET_SPI_CHKSUM_EN
          if (!trl_q) begin
            trl_d   = 1'b1;
            tx_sh_d = rw_q ? sum_q : 16'h0000;
            mosi_d  = rw_q & sum_q[15];
            state_d = StShift;
            cnt_d   = CntW'(1);
          end else begin
            chk_err_d = !rw_q && (rx_sh_q != sum_q);
            state_d   = StGap;
            cnt_d     = '0;
            cs_d      = 1'b1;
            done_d    = 1'b1;
            mosi_d    = 1'b0;
          end
`else
          state_d = StGap;
          cnt_d   = '0;
          cs_d    = 1'b1;
          done_d  = 1'b1;
          mosi_d  = 1'b0;
`endif
        end else if (!rw_q || hold_vld_q) begin
          // LOAD counts as the first low cycle of the next word's first bit.
          words_left_d = words_left_q - LEN_W'(1);
          tx_sh_d      = rw_q ? hold_q : 16'h0000;
          mosi_d       = rw_q & hold_q[15];
          hold_vld_d   = 1'b0;
          state_d      = StShift;
          cnt_d        = CntW'(1);
`ifdef JET_SPI_CHKSUM_EN
          if (rw_q) begin
            sum_d = sum_q + hold_q;
          end
`endif
        end
        // Otherwise underrun: hold sclk low and cs low until a tx word arrives.
      end

      StGap: begin
        if (cnt_q == GapLast) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      default: begin
        state_d = StIdle;
        cs_d    = 1'b1;
        sclk_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    // Ask for the next tx word as soon as the holding register is free.
    tx_ready_d = rw_d && (fetch_left_d != '0) && !hold_vld_d &&
                 (state_d inside {StSetup, StShift, StLoad});
  end

  // State and output registers; cs idles high so reset raises it immediately.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      bit_q        <= '0;
      words_left_q <= '0;
      fetch_left_q <= '0;
      rw_q         <= 1'b0;
      hdr_q        <= 1'b0;
      tx_sh_q      <= '0;
      rx_sh_q      <= '0;
      hold_q       <= '0;
      hold_vld_q   <= 1'b0;
      cs_q         <= 1'b1;
      sclk_q       <= 1'b0;
      mosi_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      tx_ready_q   <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_data_q    <= '0;
      miso_s1_q    <= 1'b0;
      miso_s2_q    <= 1'b0;
`ifdef JET_SPI_CHKSUM_EN
      sum_q        <= '0;
      trl_q        <= 1'b0;
      chk_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      words_left_q <= words_left_d;
      fetch_left_q <= fetch_left_d;
      rw_q         <= rw_d;
      hdr_q        <= hdr_d;
      tx_sh_q      <= tx_sh_d;
      rx_sh_q      <= rx_sh_d;
      hold_q       <= hold_d;
      hold_vld_q   <= hold_vld_d;
      cs_q         <= cs_d;
      sclk_q       <= sclk_d;
      mosi_q       <= mosi_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      tx_ready_q   <= tx_ready_d;
      rx_valid_q   <= rx_valid_d;
      rx_data_q    <= rx_data_d;
      miso_s1_q    <= spi_miso;
      miso_s2_q    <= miso_s1_q;
`ifdef JET_SPI_CHKSUM_EN
      sum_q        <= sum_d;
      trl_q        <= trl_d;
      chk_err_q    <= chk_err_d;
`endif
    end
  end

  assign tx_ready_o = tx_ready_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign spi_cs     = cs_q;
  assign spi_sclk   = sclk_q;
  assign spi_mosi   = mosi_q;
`ifdef JET_SPI_CHKSUM_EN
  assign chk_err_o  = chk_err_q;
`endif

endmodule
